// File: rtl/overlap_framer.sv
// overlap_framer: splits a PCM stream into 50%-overlapped frames of 2*HALF samples.
// Three HALF-sample banks form a ring; each frame is the oldest resident bank plus its successor.
module overlap_framer #(
    parameter int unsigned DATA_W = 65,
    parameter int unsigned HALF   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_framer_pcmSample,
    input  logic              in_framer_valid,
    output logic              in_framer_ready,
    output logic [DATA_W-1:0] out_framer_pcmSample,
    output logic [1:0]        out_framer_firstSequence,
    output logic              out_framer_valid,
    input  logic              out_framer_ready
);
    localparam int unsigned IW = $clog2(HALF);
    localparam int unsigned RW = $clog2(2 * HALF);
    localparam int unsigned AW = $clog2(3 * HALF);

    localparam logic [IW-1:0] WI_LAST  = IW'(HALF - 1);
    localparam logic [RW-1:0] RI_HLAST = RW'(HALF - 1);
    localparam logic [RW-1:0] RI_HALF  = RW'(HALF);
    localparam logic [RW-1:0] RI_LAST  = RW'(2 * HALF - 1);
    localparam logic [AW-1:0] HALF_A   = AW'(HALF);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        wb_q, wb_d;
    logic [IW-1:0]     wi_q, wi_d;
    logic [1:0]        rb_q, rb_d;
    logic [RW-1:0]     ri_q, ri_d;
    logic [1:0]        res_q, res_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        fs_q, fs_d;
    logic              valid_q, valid_d;
    logic              seen_q, seen_d;

    logic [DATA_W-1:0] mem_q [3*HALF];

    logic              in_fire, out_fire, bank_done, bank_free, load;
    logic [RW-1:0]     nxt;
    logic [IW-1:0]     rd_idx;
    logic [AW-1:0]     rd_addr, wr_addr;

    function automatic logic [1:0] inc3(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    assign in_framer_ready          = reset && (res_q != 2'd3);
    assign out_framer_pcmSample     = data_q;
    assign out_framer_firstSequence = fs_q;
    assign out_framer_valid         = valid_q;

    always_comb begin
        state_d  = state_q;
        wb_d     = wb_q;
        wi_d     = wi_q;
        rb_d     = rb_q;
        ri_d     = ri_q;
        res_d    = res_q;
        data_d   = data_q;
        fs_d     = fs_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        load     = 1'b0;
        rd_idx   = '0;
        nxt      = ri_q + RW'(1);

        in_fire   = in_framer_valid && in_framer_ready;
        out_fire  = valid_q && out_framer_ready;
        bank_done = in_fire && (wi_q == WI_LAST);
        bank_free = out_fire && (ri_q == RI_HLAST);

        if (in_fire) begin
            wi_d = bank_done ? '0 : wi_q + IW'(1);
            if (bank_done) wb_d = inc3(wb_q);
        end
        if (bank_free) rb_d = inc3(rb_q);

        case ({bank_done, bank_free})
            2'b10:   res_d = res_q + 2'd1;
            2'b01:   res_d = res_q - 2'd1;
            default: res_d = res_q;
        endcase

        case (state_q)
            IDLE: begin
                if (res_q >= 2'd2) begin
                    load    = 1'b1;
                    ri_d    = '0;
                    fs_d    = {!seen_q, 1'b1};
                    seen_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (ri_q != RI_LAST) begin
                        load   = 1'b1;
                        ri_d   = nxt;
                        rd_idx = (nxt < RI_HALF) ? IW'(nxt) : IW'(nxt - RI_HALF);
                        fs_d   = {fs_q[1], 1'b0};
                    end else if (res_d >= 2'd2) begin
                        load = 1'b1;
                        ri_d = '0;
                        fs_d = 2'b01;
                    end else begin
                        valid_d = 1'b0;
                        fs_d    = 2'b00;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The older bank is freed as its last sample leaves, so rb_d already names
        // the bank holding the next sample in both halves of the frame.
        rd_addr = AW'(rb_d) * HALF_A + AW'(rd_idx);
        wr_addr = AW'(wb_q) * HALF_A + AW'(wi_q);
        if (load) data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem_q[wr_addr] <= in_framer_pcmSample;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wb_q    <= '0;
            wi_q    <= '0;
            rb_q    <= '0;
            ri_q    <= '0;
            res_q   <= '0;
            data_q  <= '0;
            fs_q    <= '0;
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            wi_q    <= wi_d;
            rb_q    <= rb_d;
            ri_q    <= ri_d;
            res_q   <= res_d;
            data_q  <= data_d;
            fs_q    <= fs_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
        end
    end
endmodule
